vote_session_ctrl: RTL and testbench

Sequencing controller for the 4-voter majority system. It opens a voting session on `start` and accepts at most one ballot per voter, in parallel with no arbitration loss. The session closes when all four voters have voted or a cycle window expires. It then computes the yes count and the pass/fail result, and holds them for the display logic until the next session.

---
 rtl/vote_session_ctrl.sv | 136 +++++++++++++
 tb/tb_vote_session_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_session_ctrl.sv
// Session controller for the 4-voter majority system: opens on start, takes at most one
// ballot per voter until all have voted or the window expires, then tallies and holds the result.
module vote_session_ctrl #(
  parameter int WINDOW_CYCLES  = 16,
  parameter int PASS_THRESHOLD = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] vote_req,
  input  logic [3:0] vote_val,
  output logic [3:0] vote_ack,
  output logic [3:0] voted_mask,
  output logic       busy,
  output logic       done,
  output logic       result,
  output logic [2:0] yes_count,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPEN   = 2'd1,
    DECIDE = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t     state_r;
  state_t     state_nx_s;
  logic [3:0] accept_s;
  logic       full_next_s;
  logic       expire_s;
  logic       close_s;
  logic [2:0] tally_s;

  logic [7:0] count_r;
  logic [3:0] ballot_r;
  logic [3:0] vote_ack_r;
  logic [3:0] voted_mask_r;
  logic       busy_r;
  logic       done_r;
  logic       result_r;
  logic [2:0] yes_count_r;
  logic       timeout_r;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Non-voters hold whatever is left in ballot_r, so mask them out of the tally.
  assign tally_s = popcount4(ballot_r & voted_mask_r);

  // Next-state decode plus per-cycle ballot acceptance and close detection.
  always_comb begin
    state_nx_s  = state_r;
    accept_s    = 4'b0000;
    full_next_s = 1'b0;
    expire_s    = 1'b0;
    close_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) state_nx_s = OPEN;
        else       state_nx_s = IDLE;
      end
      OPEN: begin
        accept_s    = vote_req & ~voted_mask_r;
        full_next_s = ((voted_mask_r | accept_s) == 4'b1111);
        expire_s    = (count_r == 8'(WINDOW_CYCLES - 1));
        close_s     = full_next_s | expire_s;
        if (close_s) state_nx_s = DECIDE;
        else         state_nx_s = OPEN;
      end
      DECIDE: state_nx_s = RESULT;
      RESULT: begin
        if (start) state_nx_s = OPEN;
        else       state_nx_s = RESULT;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State, session registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      count_r      <= 8'd0;
      ballot_r     <= 4'b0000;
      vote_ack_r   <= 4'b0000;
      voted_mask_r <= 4'b0000;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      result_r     <= 1'b0;
      yes_count_r  <= 3'd0;
      timeout_r    <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      vote_ack_r <= accept_s;
      done_r     <= (state_r == DECIDE);
      busy_r     <= (state_nx_s == OPEN) || (state_nx_s == DECIDE);
      case (state_r)
        IDLE, RESULT: begin
          if (start) begin
            count_r      <= 8'd0;
            ballot_r     <= 4'b0000;
            voted_mask_r <= 4'b0000;
            result_r     <= 1'b0;
            yes_count_r  <= 3'd0;
            timeout_r    <= 1'b0;
          end
        end
        OPEN: begin
          count_r      <= count_r + 8'd1;
          voted_mask_r <= voted_mask_r | accept_s;
          ballot_r     <= (ballot_r & ~accept_s) | (vote_val & accept_s);
          if (close_s) timeout_r <= expire_s & ~full_next_s;
        end
        DECIDE: begin
          yes_count_r <= tally_s;
          result_r    <= (tally_s >= 3'(PASS_THRESHOLD));
        end
        default: begin
          count_r <= 8'd0;
        end
      endcase
    end
  end

  assign vote_ack   = vote_ack_r;
  assign voted_mask = voted_mask_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign result     = result_r;
  assign yes_count  = yes_count_r;
  assign timeout    = timeout_r;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Scoreboard bench for vote_session_ctrl: directed sessions push expected acks and results,
// a negedge monitor pops and compares them whenever the DUT pulses vote_ack or done.
module tb_vote_session_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] vote_req;
  logic [3:0] vote_val;
  logic [3:0] vote_ack;
  logic [3:0] voted_mask;
  logic       busy;
  logic       done;
  logic       result;
  logic [2:0] yes_count;
  logic       timeout;

  vote_session_ctrl #(.WINDOW_CYCLES(16), .PASS_THRESHOLD(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vote_req(vote_req), .vote_val(vote_val),
    .vote_ack(vote_ack), .voted_mask(voted_mask), .busy(busy), .done(done),
    .result(result), .yes_count(yes_count), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [3:0] ack;
  } ack_exp_t;

  typedef struct {
    int         at;
    logic [3:0] mask;
    logic [2:0] yes;
    logic       res;
    logic       tmo;
  } done_exp_t;

  ack_exp_t  ack_q[$];
  done_exp_t done_q[$];
  ack_exp_t  ea;
  done_exp_t ed;
  int n_tests = 0;
  int n_fail  = 0;

  // Monitor: every ack/done pulse must match the head of its queue, and nothing may go missing.
  always @(negedge clk) begin
    while (ack_q.size() > 0 && ack_q[0].at < cyc) begin
      n_tests++; n_fail++;
      $display("FAIL ack_missing: expected ack=%b at cycle %0d, got no pulse", ack_q[0].ack, ack_q[0].at);
      void'(ack_q.pop_front());
    end
    while (done_q.size() > 0 && done_q[0].at < cyc) begin
      n_tests++; n_fail++;
      $display("FAIL done_missing: expected done at cycle %0d, got no pulse", done_q[0].at);
      void'(done_q.pop_front());
    end
    if (vote_ack !== 4'b0000) begin
      n_tests++;
      if (ack_q.size() == 0) begin
        n_fail++;
        $display("FAIL ack_unexpected: actual ack=%b at cycle %0d, required none", vote_ack, cyc);
      end else begin
        ea = ack_q.pop_front();
        if (ea.at != cyc || ea.ack !== vote_ack) begin
          n_fail++;
          $display("FAIL ack: actual %b at cycle %0d, required %b at cycle %0d",
                   vote_ack, cyc, ea.ack, ea.at);
        end
      end
    end
    if (done !== 1'b0) begin
      n_tests++;
      if (done_q.size() == 0) begin
        n_fail++;
        $display("FAIL done_unexpected: done at cycle %0d, required none", cyc);
      end else begin
        ed = done_q.pop_front();
        if (ed.at != cyc || ed.mask !== voted_mask || ed.yes !== yes_count ||
            ed.res !== result || ed.tmo !== timeout) begin
          n_fail++;
          $display("FAIL done: actual cyc=%0d mask=%b yes=%0d res=%b tmo=%b, required cyc=%0d mask=%b yes=%0d res=%b tmo=%b",
                   cyc, voted_mask, yes_count, result, timeout,
                   ed.at, ed.mask, ed.yes, ed.res, ed.tmo);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ack"},  {4'h0, vote_ack},   8'h00);
    chk({tag, "_mask"}, {4'h0, voted_mask}, 8'h00);
    chk({tag, "_busy"}, {7'h0, busy},       8'h00);
    chk({tag, "_done"}, {7'h0, done},       8'h00);
    chk({tag, "_res"},  {7'h0, result},     8'h00);
    chk({tag, "_yes"},  {5'h0, yes_count},  8'h00);
    chk({tag, "_tmo"},  {7'h0, timeout},    8'h00);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic start_session(output int n);
    start = 1'b1;
    step();
    n = cyc;
    start = 1'b0;
  endtask

  // Present a ballot so that it is sampled on posedge number e.
  task automatic vote_at(input int e, input logic [3:0] req, input logic [3:0] val);
    wait_until(e - 1);
    vote_req = req;
    vote_val = val;
    step();
    vote_req = 4'b0000;
    vote_val = 4'b0000;
  endtask

  function automatic ack_exp_t mk_ack(input int at, input logic [3:0] a);
    mk_ack.at  = at;
    mk_ack.ack = a;
  endfunction

  function automatic done_exp_t mk_done(input int at, input logic [3:0] m, input logic [2:0] y,
                                        input logic r, input logic t);
    mk_done.at = at; mk_done.mask = m; mk_done.yes = y; mk_done.res = r; mk_done.tmo = t;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int m;
    rst_n = 1'b0; start = 1'b0; vote_req = 4'b0000; vote_val = 4'b0000;
    step(); step();
    chk_idle("reset");
    rst_n = 1'b1;
    step();

    // All four vote in the first OPEN cycle: 1011 -> 3 yes, pass.
    start_session(n);
    ack_q.push_back(mk_ack(n + 1, 4'b1111));
    done_q.push_back(mk_done(n + 2, 4'b1111, 3'd3, 1'b1, 1'b0));
    chk("open_busy", {7'h0, busy}, 8'h01);
    vote_at(n + 1, 4'b1111, 4'b1011);
    wait_until(n + 4);

    // Voters 0 and 2 only, window expires.
    start_session(n);
    ack_q.push_back(mk_ack(n + 2, 4'b0001));
    ack_q.push_back(mk_ack(n + 5, 4'b0100));
    done_q.push_back(mk_done(n + 17, 4'b0101, 3'd2, 1'b0, 1'b1));
    vote_at(n + 2, 4'b0001, 4'b0001);
    vote_at(n + 5, 4'b0100, 4'b0100);
    wait_until(n + 19);

    // Repeat request from voter 1 is ignored and does not overwrite the yes.
    start_session(n);
    ack_q.push_back(mk_ack(n + 1, 4'b0010));
    ack_q.push_back(mk_ack(n + 3, 4'b1101));
    done_q.push_back(mk_done(n + 4, 4'b1111, 3'd1, 1'b0, 1'b0));
    vote_at(n + 1, 4'b0010, 4'b0010);
    vote_at(n + 2, 4'b0010, 4'b0000);
    vote_at(n + 3, 4'b1101, 4'b0000);
    wait_until(n + 6);

    // Last ballot lands in the expiring cycle: full wins, ballot counted.
    start_session(n);
    ack_q.push_back(mk_ack(n + 1, 4'b0111));
    ack_q.push_back(mk_ack(n + 16, 4'b1000));
    done_q.push_back(mk_done(n + 17, 4'b1111, 3'd4, 1'b1, 1'b0));
    vote_at(n + 1, 4'b0111, 4'b0111);
    vote_at(n + 16, 4'b1000, 4'b1000);
    wait_until(n + 19);

    // Reset mid-session after two ballots: no done, clean restart.
    start_session(n);
    ack_q.push_back(mk_ack(n + 1, 4'b0001));
    ack_q.push_back(mk_ack(n + 2, 4'b0100));
    vote_at(n + 1, 4'b0001, 4'b0001);
    vote_at(n + 2, 4'b0100, 4'b0100);
    rst_n = 1'b0;
    step();
    chk_idle("midreset");
    rst_n = 1'b1;
    wait_until(n + 25);
    chk("idle_after_reset_busy", {7'h0, busy}, 8'h00);
    start_session(m);
    done_q.push_back(mk_done(m + 17, 4'b0000, 3'd0, 1'b0, 1'b1));
    chk("restart_mask", {4'h0, voted_mask}, 8'h00);
    chk("restart_busy", {7'h0, busy}, 8'h01);
    wait_until(m + 19);

    // Restart from RESULT with start and vote_req together.
    start_session(n);
    ack_q.push_back(mk_ack(n + 1, 4'b1111));
    done_q.push_back(mk_done(n + 2, 4'b1111, 3'd4, 1'b1, 1'b0));
    vote_at(n + 1, 4'b1111, 4'b1111);
    wait_until(n + 3);
    chk("result_hold_res", {7'h0, result}, 8'h01);
    chk("result_hold_busy", {7'h0, busy}, 8'h00);
    start = 1'b1; vote_req = 4'b1111; vote_val = 4'b1111;
    step();
    m = cyc;
    start = 1'b0; vote_req = 4'b0000; vote_val = 4'b0000;
    done_q.push_back(mk_done(m + 17, 4'b0000, 3'd0, 1'b0, 1'b1));
    chk("reopen_busy", {7'h0, busy},       8'h01);
    chk("reopen_mask", {4'h0, voted_mask}, 8'h00);
    chk("reopen_res",  {7'h0, result},     8'h00);
    chk("reopen_yes",  {5'h0, yes_count},  8'h00);
    chk("reopen_tmo",  {7'h0, timeout},    8'h00);
    chk("reopen_ack",  {4'h0, vote_ack},   8'h00);
    wait_until(m + 20);

    chk("ack_q_drained",  8'(ack_q.size()),  8'h00);
    chk("done_q_drained", 8'(done_q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
